// File: rtl/dll_sar_pkg.sv
// dll_sar_pkg: shared state encodings and the midscale helper for the
// FMDLL delay-line SAR controller and its delay-line code decoder.
package dll_sar_pkg;

  // Widest code any instance may use; midscale() returns this many bits.
  localparam int MAX_WIDTH = 16;

  // Controller state encodings (kept as plain constants for legacy users).
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SEARCH = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;
  localparam logic [1:0] ST_TRACK  = 2'd3;

  // Same encodings as an enum, for decoders and debug views.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_DONE   = 2'd2,
    S_TRACK  = 2'd3
  } sar_state_e;

  // Midscale code for a given width: MSB set, all other bits clear.
  function automatic logic [MAX_WIDTH-1:0] midscale(input int width);
    logic [MAX_WIDTH-1:0] m;
    m = '0;
    m[width-1] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/sar_track_filter.sv
// sar_track_filter: run-length filter on the phase decision. Requests a
// single +1/-1 code step after TRACK_CNT consecutive identical decisions,
// suppressing any step that would leave the code range.
module sar_track_filter #(
  parameter int WIDTH     = 10,
  parameter int TRACK_CNT = 4
) (
  input  logic             clk4,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_comp,
  input  logic [WIDTH-1:0] i_code,
  output logic             o_step_up,
  output logic             o_step_dn
);

  localparam logic [3:0] CNT_TARGET = 4'(TRACK_CNT);

  logic       r_dir;
  logic [3:0] r_cnt;
  logic [3:0] w_run;
  logic       w_hit;

  // Length of the current run including this edge's decision.
  always_comb begin
    w_run = (i_comp == r_dir) ? (r_cnt + 4'd1) : 4'd1;
    w_hit = (w_run == CNT_TARGET);
  end

  // Step requests; the counter still clears at a saturated bound.
  assign o_step_up = i_en & w_hit &  i_comp & ~(&i_code);
  assign o_step_dn = i_en & w_hit & ~i_comp &  (|i_code);

  // Direction flag and run counter; held cleared whenever tracking is off.
  always_ff @(posedge clk4 or negedge rst_n) begin
    if (!rst_n) begin
      r_dir <= 1'b0;
      r_cnt <= 4'd0;
    end else if (!i_en) begin
      r_dir <= 1'b0;
      r_cnt <= 4'd0;
    end else begin
      r_dir <= i_comp;
      r_cnt <= w_hit ? 4'd0 : w_run;
    end
  end

endmodule

// File: rtl/dll_sar_ctrl.sv
// dll_sar_ctrl: successive-approximation controller for the FMDLL delay-line
// code. One bit per clk4 edge, MSB first, from the phase detector decision.
// Build option: define DLL_SAR_TRACK_EN to continue in filtered +/-1
// tracking after the search instead of freezing the code.
module dll_sar_ctrl
  import dll_sar_pkg::*;
#(
  parameter int WIDTH     = 10,
  parameter int TRACK_CNT = 4
) (
  input  logic             clk4,
  input  logic             rst_n,
  input  logic             start,
  input  logic             comp,
  output logic [WIDTH-1:0] code,
  output logic [WIDTH-1:0] code_next,
  output logic             busy,
  output logic             done,
  output logic             lock
);

  localparam int                   IDX_W    = $clog2(WIDTH);
  localparam logic [MAX_WIDTH-1:0] MID_FULL = midscale(WIDTH);
  localparam logic [WIDTH-1:0]     MID      = MID_FULL[WIDTH-1:0];
  localparam logic [WIDTH-1:0]     CODE_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0]     IDX_TOP  = IDX_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0]     IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
`ifdef DLL_SAR_TRACK_EN
  localparam logic [1:0]           ST_FINAL = ST_TRACK;
`else
  localparam logic [1:0]           ST_FINAL = ST_DONE;
`endif

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_code;
  logic [IDX_W-1:0] r_idx;
  logic             r_done;

  logic [1:0]       w_state_next;
  logic [WIDTH-1:0] w_code_next;
  logic [IDX_W-1:0] w_idx_next;
  logic             w_done_next;
  logic             w_step_up;
  logic             w_step_dn;

`ifdef DLL_SAR_TRACK_EN
  logic w_track_en;

  // The filter runs only while tracking; a start request clears it.
  assign w_track_en = (r_state == ST_TRACK) & ~start;

  sar_track_filter #(
    .WIDTH     (WIDTH),
    .TRACK_CNT (TRACK_CNT)
  ) u_track (
    .clk4      (clk4),
    .rst_n     (rst_n),
    .i_en      (w_track_en),
    .i_comp    (comp),
    .i_code    (r_code),
    .o_step_up (w_step_up),
    .o_step_dn (w_step_dn)
  );
`else
  localparam logic [3:0] TRACK_CNT_L = 4'(TRACK_CNT);
  logic w_unused_track_cnt;

  // Without tracking the code never steps after lock.
  assign w_step_up          = 1'b0;
  assign w_step_dn          = 1'b0;
  assign w_unused_track_cnt = ^TRACK_CNT_L;
`endif

  // Next-state / next-code logic; start overrides every other transition.
  always_comb begin
    w_state_next = r_state;
    w_code_next  = r_code;
    w_idx_next   = r_idx;
    w_done_next  = 1'b0;
    if (start) begin
      w_state_next = ST_SEARCH;
      w_code_next  = MID;
      w_idx_next   = IDX_TOP;
    end else begin
      case (r_state)
        ST_SEARCH: begin
          // Resolve bit idx from the decision, then trial-set the next bit.
          w_code_next[r_idx] = comp;
          if (r_idx != '0) begin
            w_code_next[r_idx - IDX_ONE] = 1'b1;
            w_idx_next                   = r_idx - IDX_ONE;
          end else begin
            w_state_next = ST_FINAL;
            w_done_next  = 1'b1;
          end
        end
        ST_TRACK: begin
          if (w_step_up) begin
            w_code_next = r_code + CODE_ONE;
          end else if (w_step_dn) begin
            w_code_next = r_code - CODE_ONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // State, code, bit index and the completion pulse register.
  always_ff @(posedge clk4 or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_code  <= MID;
      r_idx   <= IDX_TOP;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_code  <= w_code_next;
      r_idx   <= w_idx_next;
      r_done  <= w_done_next;
    end
  end

  assign code      = r_code;
  assign code_next = w_code_next;
  assign busy      = (r_state == ST_SEARCH);
  assign lock      = (r_state == ST_DONE) | (r_state == ST_TRACK);
  assign done      = r_done;

endmodule

// File: tb/tb_dll_sar_ctrl.sv
// tb_dll_sar_ctrl: table vectors, hand-written corner sequences and a
// randomized run against a behavioural model of the SAR controller.
module tb_dll_sar_ctrl;

  localparam int W    = 10;
  localparam int TCNT = 4;
  localparam int MAXC = (1 << W) - 1;
  localparam int MIDC = 1 << (W - 1);

  logic         clk4  = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         comp  = 1'b0;
  logic [W-1:0] code;
  logic [W-1:0] code_next;
  logic         busy;
  logic         done;
  logic         lock;

  int checks = 0;
  int errors = 0;

  always #5 clk4 = ~clk4;

  dll_sar_ctrl #(
    .WIDTH     (W),
    .TRACK_CNT (TCNT)
  ) dut (
    .clk4      (clk4),
    .rst_n     (rst_n),
    .start     (start),
    .comp      (comp),
    .code      (code),
    .code_next (code_next),
    .busy      (busy),
    .done      (done),
    .lock      (lock)
  );

  typedef struct {
    bit s;
    bit c;
    int ecode;
    bit ebusy;
    bit edone;
    bit elock;
  } vec_t;

  vec_t vecs[12];

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 searching, 2 locked. During a search the code is the
  // resolved prefix followed by a trial 1 and zeros.
  int m_mode, m_n, m_val, m_code, m_dir, m_run;
  bit m_done;

  function automatic void m_reset();
    m_mode = 0; m_n = 0; m_val = 0; m_code = MIDC;
    m_dir = 0; m_run = 0; m_done = 1'b0;
  endfunction

  function automatic void m_edge(input bit s, input bit c);
    m_done = 1'b0;
    if (s) begin
      m_mode = 1; m_n = 0; m_val = 0; m_code = MIDC;
    end else if (m_mode == 1) begin
      m_val = m_val * 2 + int'(c);
      m_n++;
      if (m_n == W) begin
        m_code = m_val; m_mode = 2; m_done = 1'b1; m_dir = 0; m_run = 0;
      end else begin
        m_code = (m_val << (W - m_n)) + (1 << (W - m_n - 1));
      end
    end else if (m_mode == 2) begin
`ifdef DLL_SAR_TRACK_EN
      if (int'(c) == m_dir) m_run++;
      else begin m_dir = int'(c); m_run = 1; end
      if (m_run == TCNT) begin
        m_run = 0;
        if (c && m_code < MAXC) m_code++;
        if (!c && m_code > 0) m_code--;
      end
`endif
    end
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int ecode, input bit eb,
                         input bit ed, input bit el);
    chk({tag, " code"}, int'(code), ecode);
    chk({tag, " busy"}, int'(busy), int'(eb));
    chk({tag, " done"}, int'(done), int'(ed));
    chk({tag, " lock"}, int'(lock), int'(el));
  endtask

  task automatic drive_edge(input bit s, input bit c);
    start = s;
    comp  = c;
    @(posedge clk4);
    #1;
  endtask

  task automatic search(input int value);
    drive_edge(1'b1, 1'b0);
    for (int k = W - 1; k >= 0; k--) drive_edge(1'b0, value[k]);
  endtask

  int done_cnt;
  bit rc;
  bit rs;

  initial begin
    // --- reset values ---
    #12;
    chk_out("reset", MIDC, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // --- table: search for 0x2A5 ---
    vecs[0]  = '{1'b1, 1'b0, 'h200, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 'h300, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 'h280, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 'h2C0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 'h2A0, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 'h2B0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 'h2A8, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 'h2A4, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 'h2A6, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 'h2A5, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 'h2A5, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 'h2A5, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 12; i++) begin
      start = vecs[i].s;
      comp  = vecs[i].c;
      #1;
      chk($sformatf("vec%0d code_next", i), int'(code_next), vecs[i].ecode);
      @(posedge clk4);
      #1;
      chk_out($sformatf("vec%0d", i), vecs[i].ecode, vecs[i].ebusy,
              vecs[i].edone, vecs[i].elock);
      $display("vec %0d start=%0b comp=%0b code=0x%0h busy=%0b done=%0b lock=%0b",
               i, vecs[i].s, vecs[i].c, code, busy, done, lock);
    end

`ifdef DLL_SAR_TRACK_EN
    // --- tracking from 0x2A5: eight leads step up twice ---
    for (int i = 0; i < 8; i++) drive_edge(1'b0, 1'b1);
    chk_out("track up8", 'h2A7, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      drive_edge(1'b0, i[0]);
      chk($sformatf("track alt%0d code", i), int'(code), 'h2A7);
    end
    $display("track phase code=0x%0h lock=%0b", code, lock);
`else
    // --- frozen after lock: comp ignored ---
    for (int i = 0; i < 50; i++) begin
      drive_edge(1'b0, 1'($urandom_range(0, 1)));
      chk($sformatf("frozen%0d code", i), int'(code), 'h2A5);
      chk($sformatf("frozen%0d lock", i), int'(lock), 1);
    end
    $display("frozen phase code=0x%0h lock=%0b", code, lock);
`endif

    // --- all leads -> full scale, held there by saturation ---
    search(MAXC);
    chk_out("ones", MAXC, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 12; i++) drive_edge(1'b0, 1'b1);
    chk_out("ones hold", MAXC, 1'b0, 1'b0, 1'b1);

    // --- all lags -> zero ---
    search(0);
    chk_out("zeros", 0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 12; i++) drive_edge(1'b0, 1'b0);
    chk_out("zeros hold", 0, 1'b0, 1'b0, 1'b1);

    // --- reset mid-search, asynchronous ---
    drive_edge(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) drive_edge(1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_out("midrst", MIDC, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b1;

    // --- restart at E5 ---
    done_cnt = 0;
    drive_edge(1'b1, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      drive_edge(1'b0, 1'b1);
      done_cnt += int'(done);
    end
    start = 1'b1;
    #1;
    chk("restart code_next", int'(code_next), MIDC);
    @(posedge clk4);
    #1;
    chk_out("restart E5", MIDC, 1'b1, 1'b0, 1'b0);
    for (int i = 6; i <= 15; i++) begin
      drive_edge(1'b0, i[0]);
      done_cnt += int'(done);
      chk($sformatf("restart E%0d done", i), int'(done), (i == 15) ? 1 : 0);
    end
    drive_edge(1'b0, 1'b0);
    done_cnt += int'(done);
    chk("restart done count", done_cnt, 1);
    chk("restart code", int'(code), 'h155);

    // --- start held high: search never completes ---
    for (int i = 0; i < 15; i++) begin
      drive_edge(1'b1, 1'b1);
      chk($sformatf("held%0d done", i), int'(done), 0);
    end
    chk_out("held", MIDC, 1'b1, 1'b0, 1'b0);

    // --- randomized run against the model ---
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    m_reset();
    rc = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        #1;
        m_reset();
        chk_out($sformatf("rnd%0d rst", i), m_code, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
      end
      rs = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 3) == 0) rc = ~rc;
      m_edge(rs, rc);
      start = rs;
      comp  = rc;
      #1;
      chk($sformatf("rnd%0d code_next", i), int'(code_next), m_code);
      @(posedge clk4);
      #1;
      chk_out($sformatf("rnd%0d", i), m_code, m_mode == 1, m_done, m_mode == 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
